barret_inv_for_1483: RTL and testbench

BARRET_INV_FOR_1483 -- requirements
Module: barret_inv_for_1483

---
 rtl/barret_1483_pkg.sv | 16 +
 rtl/mulred_1483.sv | 26 ++
 rtl/barret_inv_for_1483.sv | 95 +++++++++
 tb/tb_barret_inv_for_1483.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/barret_1483_pkg.sv
// Shared constants and FSM state type for the modular inverter over GF(1483).
package barret_1483_pkg;
  localparam int FW = 11;
  localparam int PW = 22;
  localparam logic [FW-1:0] Q   = 11'd1483;
  localparam logic [FW-1:0] EXP = 11'd1481;
  localparam logic [11:0]   MU  = 12'd2828;
  localparam logic [3:0]    IDX_MSB = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/mulred_1483.sv
// Combinational 11x11 multiply followed by Barrett reduction modulo 1483.
module mulred_1483
  import barret_1483_pkg::*;
(
  input  logic [FW-1:0] x_a,
  input  logic [FW-1:0] x_b,
  output logic [FW-1:0] r
);
  logic [PW-1:0] prod;
  logic [23:0]   qm;
  logic [11:0]   q_hat;
  logic [PW-1:0] qq;
  logic [12:0]   r0;
  logic [12:0]   r1;
  logic [12:0]   r2;

  assign prod  = {11'b0, x_a} * {11'b0, x_b};
  assign qm    = {12'b0, prod[PW-1:10]} * {12'b0, MU};
  assign q_hat = 12'(qm >> 12);
  assign qq    = {10'b0, q_hat} * {11'b0, Q};
  // q_hat undershoots the true quotient by at most 2, so the remainder is below 3*Q < 2^13.
  assign r0    = 13'(prod - qq);
  assign r1    = (r0 >= {2'b0, Q}) ? r0 - {2'b0, Q} : r0;
  assign r2    = (r1 >= {2'b0, Q}) ? r1 - {2'b0, Q} : r1;
  assign r     = 11'(r2);
endmodule

// File: rtl/barret_inv_for_1483.sv
// Modular inverse a^-1 mod 1483 by Fermat exponentiation a^1481, square-and-multiply MSB first.
module barret_inv_for_1483
  import barret_1483_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] din_a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-1:0] dout_r,
  output logic          dout_err
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds valid and data stable until that edge.
  state_t        state, state_n;
  logic [FW-1:0] acc, acc_n;
  logic [FW-1:0] a_reg, a_n;
  logic [3:0]    idx, idx_n;
  logic          err, err_n;
  logic [FW-1:0] a_red;
  logic [FW-1:0] mul_b;
  logic [FW-1:0] mr;
  logic [15:0]   exp_bits;

  assign exp_bits = {5'b0, EXP};
  assign a_red    = (din_a >= Q) ? din_a - Q : din_a;
  assign mul_b    = (state == MUL) ? a_reg : acc;

  mulred_1483 u_mulred (
    .x_a (acc),
    .x_b (mul_b),
    .r   (mr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= 11'd1;
      a_reg <= '0;
      idx   <= IDX_MSB;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      a_reg <= a_n;
      idx   <= idx_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    a_n     = a_reg;
    idx_n   = idx;
    err_n   = err;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_n     = a_red;
          err_n   = (a_red == '0);
          acc_n   = 11'd1;
          idx_n   = IDX_MSB;
          state_n = SQR;
        end
      end
      SQR: begin
        acc_n = mr;
        if (exp_bits[idx])   state_n = MUL;
        else if (idx == 4'd0) state_n = DONE;
        else                  idx_n   = idx - 4'd1;
      end
      MUL: begin
        acc_n = mr;
        if (idx == 4'd0) begin
          state_n = DONE;
        end else begin
          idx_n   = idx - 4'd1;
          state_n = SQR;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dout_r    = out_valid ? acc : '0;
  assign dout_err  = out_valid & err;
endmodule

// File: tb/tb_barret_inv_for_1483.sv
// Scoreboard bench for barret_inv_for_1483: directed operands, back-pressure, reset abort, full sweep.
module tb_barret_inv_for_1483;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] din_a;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] dout_r;
  logic        dout_err;

  int tests;
  int fails;
  int cyc;
  logic prev_ov;
  logic [11:0] exp_q[$];
  int          hs_q[$];

  barret_inv_for_1483 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_r    (dout_r),
    .dout_err  (dout_err)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Independent reference: plain integer modular exponentiation.
  function automatic logic [11:0] ref_out(input int d);
    longint b, r;
    int e;
    b = d % 1483;
    r = 1;
    e = 1481;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % 1483;
      b = (b * b) % 1483;
      e = e / 2;
    end
    return {(d % 1483 == 0), 11'(r)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drives one operand; when track is set, the expected result and handshake cycle are queued.
  task automatic send(input int d, input logic [11:0] exp_v, input bit track);
    int budget;
    budget = 0;
    while (!in_ready && budget < 200) begin
      step();
      budget++;
    end
    check("in_ready_timeout", int'(budget < 200), 1);
    in_valid = 1'b1;
    din_a    = 11'(d);
    if (track) exp_q.push_back(exp_v);
    step();
    if (track) hs_q.push_back(cyc);
    // keep junk on the input while busy; it must be ignored
    for (int k = 0; k < 3; k++) begin
      din_a = 11'($urandom_range(0, 2047));
      step();
    end
    in_valid = 1'b0;
    din_a    = 11'($urandom_range(0, 2047));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      step();
      budget++;
    end
    check("drain_timeout", int'(budget < 200), 1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (hs_q.size() == 0) check("latency_no_handshake", 1, 0);
        else check("latency", cyc - hs_q.pop_front(), 17);
      end
      if (out_valid) begin
        check("in_ready_while_out_valid", int'(in_ready), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_out", int'({dout_err, dout_r}), -1);
        end else begin
          check("dout_err", int'(dout_err), int'(exp_q[0][11]));
          check("dout_r", int'(dout_r), int'(exp_q[0][10:0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
    prev_ov = out_valid;
  end

  // watchdog
  initial begin
    #900000;
    fails++;
    tests++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    prev_ov   = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din_a     = '0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout_r", int'(dout_r), 0);
    check("rst_dout_err", int'(dout_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // directed vectors, hand-computed
    send(2,    {1'b0, 11'd742},  1'b1);
    send(3,    {1'b0, 11'd989},  1'b1);
    send(1,    {1'b0, 11'd1},    1'b1);
    send(1482, {1'b0, 11'd1482}, 1'b1);
    send(0,    {1'b1, 11'd0},    1'b1);
    send(1484, {1'b0, 11'd1},    1'b1);
    send(1483, {1'b1, 11'd0},    1'b1);
    send(2047, ref_out(2047),    1'b1);
    drain();

    // back-pressure: result must hold for 5 stalled cycles
    out_ready = 1'b0;
    send(2, {1'b0, 11'd742}, 1'b1);
    for (int k = 0; k < 14; k++) step();
    check("bp_out_valid", int'(out_valid), 1);
    for (int k = 0; k < 5; k++) step();
    check("bp_hold_valid", int'(out_valid), 1);
    check("bp_hold_r", int'(dout_r), 742);
    out_ready = 1'b1;
    step();
    check("bp_in_ready_after", int'(in_ready), 1);
    drain();

    // reset during computation discards the operation
    send(2, 12'd0, 1'b0);
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_dout_r", int'(dout_r), 0);
    check("abort_dout_err", int'(dout_err), 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) step();
    check("abort_no_output", exp_q.size(), 0);
    send(3, {1'b0, 11'd989}, 1'b1);
    drain();

    // full sweep against the reference model
    for (int a = 1; a < 1483; a++) begin
      logic [11:0] e;
      e = ref_out(a);
      check("ref_sanity", int'((longint'(a) * longint'(e[10:0])) % 1483), 1);
      send(a, e, 1'b1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
